// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sequencer
// Purpose  : Pipeline hazard controller for the 5-stage core with a
//            multi-cycle multiplier in EX. Each cycle it decides whether the
//            PC, IF/ID and ID/EX registers advance, hold or take a bubble, and
//            whether EX/MEM takes a bubble. Handles load-use stalls, multiply
//            occupancy of EX and wrong-path kill from a branch resolved in MEM.
//            Priority: mem_flush > multiply > load-use.
// Ports    : clk, arst                    - clock, async active-high reset
//            id_rs1/id_rs2, id_uses_rs*   - ID source operands
//            ex_valid, ex_rd, ex_reg_write,
//            ex_mem_read, ex_is_mult      - EX instruction info
//            mem_flush                    - taken branch/jump resolved in MEM
//            pc_write_en, if_id_write_en,
//            id_ex_write_en               - stage register enables
//            if_id_flush, id_ex_bubble,
//            ex_mem_bubble                - NOP / bubble insertion
//            mult_start/done/abort        - one-cycle multiplier pulses
//            mult_busy                    - multiply occupying EX
//            stall_cnt                    - saturating PC-freeze cycle count
// Revision : 1.0 - initial release
// ============================================================================
module hazard_sequencer #(
    parameter int MULT_LATENCY = 4,
    parameter int REG_ADDR_W   = 5,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   ex_valid,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic                   ex_is_mult,
    input  logic                   mem_flush,
    output logic                   pc_write_en,
    output logic                   if_id_write_en,
    output logic                   id_ex_write_en,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_bubble,
    output logic                   mult_start,
    output logic                   mult_done,
    output logic                   mult_abort,
    output logic                   mult_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MULT = 1'b1
    } state_t;

    // The start cycle counts as cycle 1, so MULT ends at MULT_LATENCY-1.
    localparam logic [3:0]             c_CNT_LAST  = 4'(MULT_LATENCY - 1);
    localparam logic [STALL_CNT_W-1:0] c_STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_load_use;

    // Register 0 is hardwired zero, so a load targeting it never stalls.
    assign w_load_use = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != '0) &
                        ((id_uses_rs1 & (ex_rd == id_rs1)) |
                         (id_uses_rs2 & (ex_rd == id_rs2)));

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_mem_bubble  = 1'b0;
        mult_start     = 1'b0;
        mult_done      = 1'b0;
        mult_abort     = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;

        // While reset is held the outputs stay at the IDLE defaults even if
        // the inputs describe a multiply or a hazard.
        if (!arst) begin
            if (mem_flush) begin
                // Wrong path: kill IF, ID and EX, let the pipeline refill.
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
                if (r_state == S_MULT) begin
                    mult_abort  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end else if (r_state == S_IDLE) begin
                if (ex_valid && ex_is_mult) begin
                    // ID/EX keeps the multiply; EX/MEM sees bubbles meanwhile.
                    mult_start     = 1'b1;
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_write_en = 1'b0;
                    ex_mem_bubble  = 1'b1;
                    w_state_nxt    = S_MULT;
                    w_cnt_nxt      = 4'd1;
                end else if (w_load_use) begin
                    // Freeze PC and IF/ID for one cycle, bubble into ID/EX.
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                end
            end else begin
                if (r_cnt < c_CNT_LAST) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_write_en = 1'b0;
                    ex_mem_bubble  = 1'b1;
                    w_cnt_nxt      = r_cnt + 4'd1;
                end else begin
                    // Result enters EX/MEM; a dependent op in ID forwards from there.
                    mult_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!pc_write_en && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
            end
        end
    end

    assign mult_busy = (r_state == S_MULT);
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sequencer
// Purpose  : Directed self-checking bench for hazard_sequencer
//            (MULT_LATENCY = 4, STALL_CNT_W = 4 so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

    localparam int LAT = 4;
    localparam int AW  = 5;
    localparam int SW  = 4;

    // Output vector order:
    // {pc, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, ex_mem_bubble,
    //  start, done, abort, busy}
    localparam logic [9:0] c_DEF   = 10'b1110000000;
    localparam logic [9:0] c_LU    = 10'b0010100000;
    localparam logic [9:0] c_START = 10'b0000011000;
    localparam logic [9:0] c_HOLD  = 10'b0000010001;
    localparam logic [9:0] c_DONE  = 10'b1110000101;
    localparam logic [9:0] c_ABORT = 10'b1111110011;
    localparam logic [9:0] c_FLUSH = 10'b1111110000;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_valid;
    logic          ex_reg_write, ex_mem_read, ex_is_mult, mem_flush;
    logic          pc_write_en, if_id_write_en, id_ex_write_en;
    logic          if_id_flush, id_ex_bubble, ex_mem_bubble;
    logic          mult_start, mult_done, mult_abort, mult_busy;
    logic [SW-1:0] stall_cnt;
    logic [9:0]    outs;

    int total = 0;
    int bad   = 0;

    logic [9:0] mult_seq [4];

    always #5 clk = ~clk;

    hazard_sequencer #(
        .MULT_LATENCY (LAT),
        .REG_ADDR_W   (AW),
        .STALL_CNT_W  (SW)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_is_mult     (ex_is_mult),
        .mem_flush      (mem_flush),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .id_ex_write_en (id_ex_write_en),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_bubble  (ex_mem_bubble),
        .mult_start     (mult_start),
        .mult_done      (mult_done),
        .mult_abort     (mult_abort),
        .mult_busy      (mult_busy),
        .stall_cnt      (stall_cnt)
    );

    assign outs = {pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush,
                   id_ex_bubble, ex_mem_bubble, mult_start, mult_done,
                   mult_abort, mult_busy};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic [9:0] expv);
        check(tag, {22'd0, outs}, {22'd0, expv});
    endtask

    task automatic chk_cnt(input string tag, input int expv);
        check(tag, {28'd0, stall_cnt}, 32'(expv));
    endtask

    task automatic clr_in();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_is_mult = 1'b0; mem_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        clr_in();
        arst = 1'b1;
        #1;
        arst = 1'b0;
        tick();
    endtask

    task automatic set_mult();
        ex_valid = 1'b1; ex_is_mult = 1'b1;
    endtask

    // lw x5 in EX, add reading x3/x5 in ID
    task automatic set_load_use();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd3; id_rs2 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    endtask

    initial begin
        mult_seq[0] = c_START;
        mult_seq[1] = c_HOLD;
        mult_seq[2] = c_HOLD;
        mult_seq[3] = c_DONE;

        // Reset state
        clr_in();
        arst = 1'b1;
        #3;
        chk_out("reset_outs", c_DEF);
        chk_cnt("reset_cnt", 0);
        tick();
        arst = 1'b0;

        // Load-use on rs2
        set_load_use();
        settle();
        chk_out("lu_rs2", c_LU);
        tick();
        clr_in();
        settle();
        chk_out("lu_after", c_DEF);
        chk_cnt("lu_cnt1", 1);

        // Load to x0 never stalls
        set_load_use();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        settle();
        chk_out("lu_rd0", c_DEF);
        tick();
        chk_cnt("lu_rd0_cnt", 1);

        // rs2 matches but is not read
        set_load_use();
        id_uses_rs2 = 1'b0;
        settle();
        chk_out("lu_nors2", c_DEF);

        // Match through rs1
        tick();
        set_load_use();
        id_rs1 = 5'd5; id_rs2 = 5'd7;
        settle();
        chk_out("lu_rs1", c_LU);
        tick();
        clr_in();
        settle();
        chk_cnt("lu_rs1_cnt", 2);

        // Not a register-writing load
        set_load_use();
        ex_reg_write = 1'b0;
        settle();
        chk_out("lu_noregw", c_DEF);
        tick();
        set_load_use();
        ex_valid = 1'b0;
        settle();
        chk_out("lu_novalid", c_DEF);

        // Single multiply
        do_reset();
        set_mult();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_out($sformatf("mul_c%0d", i + 1), mult_seq[i]);
            tick();
        end
        clr_in();
        settle();
        chk_out("mul_after", c_DEF);
        chk_cnt("mul_cnt", 3);

        // Back-to-back multiplies
        do_reset();
        set_mult();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk_out($sformatf("b2b_c%0d", i + 1), mult_seq[i % 4]);
            tick();
        end
        clr_in();
        settle();
        chk_out("b2b_after", c_DEF);
        chk_cnt("b2b_cnt", 6);

        // Flush at cnt = 2
        do_reset();
        set_mult();
        tick();
        tick();
        mem_flush = 1'b1;
        settle();
        chk_out("flush_mult", c_ABORT);
        tick();
        clr_in();
        settle();
        chk_out("flush_idle_next", c_DEF);
        chk_cnt("flush_cnt", 2);

        // Flush together with load-use
        set_load_use();
        mem_flush = 1'b1;
        settle();
        chk_out("flush_lu", c_FLUSH);
        tick();
        clr_in();
        settle();
        chk_cnt("flush_lu_cnt", 2);

        // Reset mid-multiply at cnt = 2
        do_reset();
        set_mult();
        tick();
        tick();
        settle();
        chk_out("rstmul_hold", c_HOLD);
        arst = 1'b1;
        #1;
        chk_out("rstmul_outs", c_DEF);
        chk_cnt("rstmul_cnt", 0);
        #1;
        arst = 1'b0;
        clr_in();
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk_out($sformatf("rstmul_post%0d", i), c_DEF);
        end

        // Saturation
        do_reset();
        set_load_use();
        for (int i = 0; i < 10; i++) tick();
        chk_cnt("sat_10", 10);
        for (int i = 0; i < 10; i++) tick();
        chk_cnt("sat_20", 15);
        clr_in();
        tick();
        chk_cnt("sat_hold", 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
